sram_responder: RTL

//  Memory-side responder for the arbitrated instruction/data SRAM request stream.
//  - Accepts one request at a time (IF fetch, MEM load, or MEM store) over a valid/ready handshake.
//  - Emulates a slow single-port memory: programmable wait states, byte-masked writes, one-word reads.
//  - Returns each response tagged with its source, so the arbiter can steer rdata back to IF or MEM.
//  - Single outstanding transaction; sits between the arbiter and the physical/simulated RAM.

---
 rtl/sram_responder_pkg.sv | 22 ++
 rtl/sram_responder_bank.sv | 45 ++++
 rtl/sram_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: requester tags, FSM encodings,
// byte-lane geometry and the latched-request record.
package sram_responder_pkg;

    localparam logic SRC_IF  = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int SRAM_DATA_W = 32;
    localparam int LANES       = SRAM_DATA_W / 8;

    typedef struct packed {
        logic                   wr;
        logic                   src;
        logic [LANES-1:0]       wstrb;
        logic [SRAM_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_responder_bank.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read port.
// A write access clears the read register so store acknowledges carry zero data.
module sram_responder_bank
    import sram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_W     = SRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_wr,
    input  logic [LANES-1:0]      i_be,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [LANES-1:0][7:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0]     r_rdata;

    // Array contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (i_en && i_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_wr ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: accepts one IF/MEM request at a time, performs it after
// WAIT_CYCLES wait states and returns a source-tagged response.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_src,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_wstrb,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_src,
    output logic              rsp_wr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    // Handshake rule for both channels: a transfer happens on a rising edge where
    // valid && ready; the producer keeps valid and payload steady until then, and
    // the responder never withdraws rsp_valid before rsp_ready.
    localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic       LP_NO_WAIT   = (WAIT_CYCLES == 0);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    req_t                  r_req;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_rsp_valid;
    logic                  r_rsp_src;
    logic                  r_rsp_wr;

    logic                  w_in_idle;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_acc_wr;
    logic                  w_acc_src;
    logic [LANES-1:0]      w_acc_strb;
    logic [DATA_W-1:0]     w_acc_wdata;
    logic [DEPTH_LOG2-1:0] w_req_idx;
    logic [DEPTH_LOG2-1:0] w_acc_idx;
    logic [DATA_W-1:0]     w_bank_rdata;
    logic                  w_unused_addr;

    assign w_in_idle     = (r_state == ST_IDLE);
    assign w_accept      = w_in_idle && req_valid && !reset;
    assign w_req_idx     = req_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{req_addr[ADDR_W-1:DEPTH_LOG2+2], req_addr[1:0]};

    // A zero-wait access happens on the accept edge itself, so it must use the
    // live request; otherwise the latched copy is used.
    assign w_acc_wr    = w_in_idle ? req_wr    : r_req.wr;
    assign w_acc_src   = w_in_idle ? req_src   : r_req.src;
    assign w_acc_strb  = w_in_idle ? req_wstrb : r_req.wstrb;
    assign w_acc_wdata = w_in_idle ? req_wdata : r_req.wdata;
    assign w_acc_idx   = w_in_idle ? w_req_idx : r_idx;

    assign w_access = (w_accept && LP_NO_WAIT)
                    || (!reset && (r_state == ST_WAIT) && (r_cnt == 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req.wr    <= req_wr;
                        r_req.src   <= req_src;
                        r_req.wstrb <= req_wstrb;
                        r_req.wdata <= req_wdata;
                        r_idx       <= w_req_idx;
                        r_cnt       <= LP_WAIT_LOAD;
                        r_state     <= LP_NO_WAIT ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_src   <= SRC_IF;
            r_rsp_wr    <= 1'b0;
        end else if (w_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_src   <= w_acc_src;
            r_rsp_wr    <= w_acc_wr;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    sram_responder_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_bank (
        .clk     (clk),
        .i_rst   (reset),
        .i_en    (w_access),
        .i_wr    (w_acc_wr),
        .i_be    (w_acc_strb),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_bank_rdata)
    );

    assign req_ready   = w_in_idle && !reset;
    assign busy        = !w_in_idle;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_src     = r_rsp_src;
    assign rsp_wr      = r_rsp_wr;
    assign rsp_rdata   = w_bank_rdata;
    assign o_dbg_state = r_state;

endmodule
